picorv32_axi_mem: RTL and testbench
===================================

PICORV32_AXI_MEM -- requirements
Module: picorv32_axi_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports mem_axi_awvalid (in, 1), mem_axi_awready (out, 1), mem_axi_awaddr (in, 32) and mem_axi_awprot (in, 3): AXI4-lite write address channel; awprot is ignored.
REQ-006 SHALL have ports mem_axi_wvalid (in, 1), mem_axi_wready (out, 1), mem_axi_wdata (in, 32) and mem_axi_wstrb (in, 4): write data channel.
REQ-007 SHALL have ports mem_axi_bvalid (out, 1), mem_axi_bready (in, 1) and mem_axi_bresp (out, 2): write response channel.
REQ-008 SHALL have ports mem_axi_arvalid (in, 1), mem_axi_arready (out, 1), mem_axi_araddr (in, 32) and mem_axi_arprot (in, 3): read address channel; arprot is ignored.
REQ-009 SHALL have ports mem_axi_rvalid (out, 1), mem_axi_rready (in, 1), mem_axi_rdata (out, 32) and mem_axi_rresp (out, 2): read data channel.

Function
REQ-010 SHALL drive mem_axi_awready = resetn && !aw_held && !bvalid, and mem_axi_wready = resetn && !w_held && !bvalid.
REQ-011 SHALL accept AW and W independently, in either order or in the same cycle, holding each in its own register until the write executes.
REQ-012 SHALL execute a write in any cycle where aw_held && w_held && !bvalid; each byte lane i is written only where wstrb[i]=1.
REQ-013 SHALL, after a write executes, clear aw_held and w_held and set bvalid at the same edge.
REQ-014 SHALL hold bvalid and bresp stable until bvalid && bready; the AW and W channels stay blocked while bvalid=1, so at most one write is outstanding.
REQ-015 SHALL drive mem_axi_arready = resetn && !ar_held && !rvalid.
REQ-016 SHALL execute a read in any cycle where ar_held=1, rvalid=0 and no write executes in that cycle.
REQ-017 SHALL, on a read-versus-write conflict in the same cycle, give the write priority and delay the read by exactly one cycle, so a read issued alongside a write to the same address returns the new data.
REQ-018 SHALL set rvalid and rdata at the edge ending the read cycle, and hold them stable until rvalid && rready.
REQ-019 SHALL give best-case latencies of 2 edges from AW+W handshake to bvalid, and 2 edges from AR handshake to rvalid.
REQ-020 SHALL compute the word index as (addr - BASE_ADDR) >> 2, and ignore addr[1:0].
REQ-021 SHALL run the read path and the write path concurrently and independently, except for the conflict rule in REQ-017.

Reset
REQ-022 SHALL, while resetn=0, force aw_held, w_held, ar_held, bvalid and rvalid to 0, rdata to 0, and bresp and rresp to 2'b00.
REQ-023 SHALL force awready, wready and arready to 0 while resetn=0.
REQ-024 SHALL abandon any transaction in flight when reset is asserted, with no response issued afterwards.
REQ-025 SHALL NOT reset memory contents.

Configuration
REQ-026 SHALL, with PICORV32_AXI_MEM_OOR_ERR_EN defined, treat a word index >= MEM_WORDS as out of range: such writes leave memory unchanged and respond bresp=2'b10 (SLVERR); such reads respond rresp=2'b10 with rdata=32'h0.
REQ-027 SHALL, with PICORV32_AXI_MEM_OOR_ERR_EN undefined, wrap the word index modulo MEM_WORDS and always respond 2'b00 (OKAY).

Structure
REQ-028 SHALL take the response-code constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 from shared package picorv32_axi_pkg.
REQ-029 SHALL place the storage in sub-module picorv32_axi_mem_ram: a single-port, byte-enable, synchronous-read RAM with ports clk, en, we[3:0], addr, wdata and rdata.

Verification
REQ-030 SHALL cover: AW 32'h10 with W 32'hDEADBEEF, strb 4'hF, same cycle; then AR 32'h10 -> bvalid 2 edges after the handshake with bresp 00; rdata 32'hDEADBEEF with rresp 00.
REQ-031 SHALL cover: W data 32'h11223344 presented 3 cycles before AW 32'h20 -> wready drops after the W handshake; write completes after AW; a read returns 32'h11223344.
REQ-032 SHALL cover: word 32'h20 preset to 32'h11223344, then write 32'hAABBCCDD with strb 4'b0101 -> a read returns 32'h11BB33DD.
REQ-033 SHALL cover: AR 32'h30 made ready in the same cycle as a write executing to 32'h30 -> rvalid is one cycle later than best case; rdata equals the new write data.
REQ-034 SHALL cover: bready held 0 for 5 cycles -> bvalid stays 1; awready and wready stay 0; a second write waits.
REQ-035 SHALL cover: with MEM_WORDS=1024, access to BASE_ADDR+32'h1000 -> SLVERR with OOR_ERR_EN defined; an alias of word 0 returning OKAY without it; plus resetn pulled low while rvalid=1 -> rvalid=0 immediately.

Source files
------------

// File: rtl/picorv32_axi_pkg.sv
// Shared AXI4-lite definitions for the PicoRV32 AXI memory slice.
package picorv32_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] byte_offset(logic [31:0] addr, logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/picorv32_axi_mem_ram.sv
// Single-port byte-enable RAM with synchronous read. The read register only
// updates on a pure read, so a returned word stays put while writes continue.
module picorv32_axi_mem_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/picorv32_axi_mem.sv
// AXI4-lite memory slave with independent read/write paths; writes win a RAM
// conflict. Define PICORV32_AXI_MEM_OOR_ERR_EN for SLVERR on out-of-range words.
module picorv32_axi_mem
  import picorv32_axi_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);

  logic        aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] awaddr_q, awaddr_d, araddr_q, araddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic [31:0] aw_off, ar_off, ram_rdata;
  logic        wr_oor, rd_oor, wr_exec, rd_exec, ram_en;
  logic [3:0]  ram_we;
  logic [AddrW-1:0] ram_addr;
  logic        unused_ok;

  assign aw_off = byte_offset(awaddr_q, BASE_ADDR);
  assign ar_off = byte_offset(araddr_q, BASE_ADDR);

`ifdef PICORV32_AXI_MEM_OOR_ERR_EN
  assign wr_oor = {2'b00, aw_off[31:2]} >= MEM_WORDS;
  assign rd_oor = {2'b00, ar_off[31:2]} >= MEM_WORDS;
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  assign mem_axi_awready = resetn && !aw_held_q && !bvalid_q;
  assign mem_axi_wready  = resetn && !w_held_q && !bvalid_q;
  assign mem_axi_arready = resetn && !ar_held_q && !rvalid_q;

  assign wr_exec = aw_held_q && w_held_q && !bvalid_q;
  assign rd_exec = ar_held_q && !rvalid_q && !wr_exec;

  // A zero-strobe write must not enable the RAM, or it would act as a read.
  assign ram_we   = (wr_exec && !wr_oor) ? wstrb_q : 4'b0000;
  assign ram_en   = (|ram_we) || (rd_exec && !rd_oor);
  assign ram_addr = wr_exec ? aw_off[AddrW+1:2] : ar_off[AddrW+1:2];

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ar_held_d = ar_held_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;

    if (mem_axi_awvalid && mem_axi_awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = mem_axi_awaddr;
    end
    if (mem_axi_wvalid && mem_axi_wready) begin
      w_held_d = 1'b1;
      wdata_d  = mem_axi_wdata;
      wstrb_d  = mem_axi_wstrb;
    end
    if (wr_exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && mem_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (mem_axi_arvalid && mem_axi_arready) begin
      ar_held_d = 1'b1;
      araddr_d  = mem_axi_araddr;
    end
    if (rd_exec) begin
      ar_held_d = 1'b0;
      rvalid_d  = 1'b1;
      rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && mem_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      ar_held_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ar_held_q <= ar_held_d;
      araddr_q  <= araddr_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  picorv32_axi_mem_ram #(
    .MEM_WORDS(MEM_WORDS),
    .ADDR_W   (AddrW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign mem_axi_bvalid = bvalid_q;
  assign mem_axi_bresp  = bresp_q;
  assign mem_axi_rvalid = rvalid_q;
  assign mem_axi_rresp  = rresp_q;
  // Masking keeps rdata at zero in reset and for out-of-range reads.
  assign mem_axi_rdata  = (rvalid_q && rresp_q == RESP_OKAY) ? ram_rdata : 32'h0;

  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, aw_off, ar_off};

endmodule

// File: tb/tb_picorv32_axi_mem.sv
// Directed self-checking bench for picorv32_axi_mem: latency, ordering,
// strobes, read/write conflict, backpressure, range handling and reset.
module tb_picorv32_axi_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picorv32_axi_mem #(
    .MEM_WORDS(1024),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_axi_awvalid(awvalid),
    .mem_axi_awready(awready),
    .mem_axi_awaddr (awaddr),
    .mem_axi_awprot (3'b000),
    .mem_axi_wvalid (wvalid),
    .mem_axi_wready (wready),
    .mem_axi_wdata  (wdata),
    .mem_axi_wstrb  (wstrb),
    .mem_axi_bvalid (bvalid),
    .mem_axi_bready (bready),
    .mem_axi_bresp  (bresp),
    .mem_axi_arvalid(arvalid),
    .mem_axi_arready(arready),
    .mem_axi_araddr (araddr),
    .mem_axi_arprot (3'b000),
    .mem_axi_rvalid (rvalid),
    .mem_axi_rready (rready),
    .mem_axi_rdata  (rdata),
    .mem_axi_rresp  (rresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic aw_done, w_done, hs_aw, hs_w;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w) begin wvalid = 1'b0; w_done = 1'b1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check_eq("wr_bvalid_seen", 32'(bvalid), 32'd1);
    resp = bresp;
    bready = 1'b1;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic done;
    int n;
    araddr = a; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      done = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check_eq("rd_handshake_done", 32'(done), 32'd1);
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check_eq("rd_rvalid_seen", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;

    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    bready = 1'b1; rready = 1'b1;
    #2;
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_eq("post_rst_awready", 32'(awready), 32'd1);

    // AW and W in the same cycle, then a read of the same word.
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    check_eq("same_cyc_aw_wready", 32'(awready && wready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_lat_edge1", 32'(bvalid), 32'd0);
    tick();
    check_eq("wr_lat_edge2", 32'(bvalid), 32'd1);
    check_eq("wr_bresp_okay", 32'(bresp), 32'd0);
    tick();
    check_eq("b_handshake_clears", 32'(bvalid), 32'd0);
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("rd_lat_edge1", 32'(rvalid), 32'd0);
    tick();
    check_eq("rd_lat_edge2", 32'(rvalid), 32'd1);
    check_eq("rd_data_10", rdata, 32'hDEADBEEF);
    check_eq("rd_rresp_okay", 32'(rresp), 32'd0);
    tick();
    check_eq("r_handshake_clears", 32'(rvalid), 32'd0);

    do_read(32'h13, rd, rsp);
    check_eq("rd_ignores_low_bits", rd, 32'hDEADBEEF);

    // W three cycles ahead of AW.
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check_eq("w_first_wready_drops", 32'(wready), 32'd0);
    tick();
    tick();
    check_eq("w_first_no_bvalid", 32'(bvalid), 32'd0);
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    check_eq("w_first_bvalid", 32'(bvalid), 32'd1);
    tick();
    do_read(32'h20, rd, rsp);
    check_eq("w_first_rdata", rd, 32'h11223344);

    // Partial strobe merge.
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, rsp);
    check_eq("strb_bresp", 32'(rsp), 32'd0);
    do_read(32'h20, rd, rsp);
    check_eq("strb_merge", rd, 32'h11BB33DD);

    // Read held in the same cycle a write to that word executes.
    do_write(32'h30, 32'h12345678, 4'hF, rsp);
    awaddr = 32'h30; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h30;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    check_eq("conflict_bvalid", 32'(bvalid), 32'd1);
    check_eq("conflict_rd_delayed", 32'(rvalid), 32'd0);
    tick();
    check_eq("conflict_rvalid", 32'(rvalid), 32'd1);
    check_eq("conflict_new_data", rdata, 32'hCAFEF00D);
    tick();

    // Write response backpressure blocks a second write.
    bready = 1'b0;
    awaddr = 32'h40; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check_eq("bp_bvalid_set", 32'(bvalid), 32'd1);
    awaddr = 32'h44; wdata = 32'h0BADCAFE; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_bvalid_held", 32'(bvalid), 32'd1);
      check_eq("bp_awready_low", 32'(awready), 32'd0);
      check_eq("bp_wready_low", 32'(wready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    check_eq("bp_released", 32'(bvalid), 32'd0);
    check_eq("bp_awready_back", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check_eq("bp_second_write_done", 32'(bvalid), 32'd1);
    tick();
    do_read(32'h40, rd, rsp);
    check_eq("bp_rd_40", rd, 32'h55AA55AA);
    do_read(32'h44, rd, rsp);
    check_eq("bp_rd_44", rd, 32'h0BADCAFE);

    // Out-of-range / aliasing at BASE_ADDR + 4 KiB.
    do_write(32'h0, 32'h01020304, 4'hF, rsp);
    do_write(32'h1000, 32'h77777777, 4'hF, rsp);
`ifdef PICORV32_AXI_MEM_OOR_ERR_EN
    check_eq("oor_wr_slverr", 32'(rsp), 32'd2);
    do_read(32'h1000, rd, rsp);
    check_eq("oor_rd_slverr", 32'(rsp), 32'd2);
    check_eq("oor_rd_zero", rd, 32'h0);
    do_read(32'h0, rd, rsp);
    check_eq("oor_word0_intact", rd, 32'h01020304);
`else
    check_eq("alias_wr_okay", 32'(rsp), 32'd0);
    do_read(32'h1000, rd, rsp);
    check_eq("alias_rd_okay", 32'(rsp), 32'd0);
    check_eq("alias_rd_data", rd, 32'h77777777);
    do_read(32'h0, rd, rsp);
    check_eq("alias_word0", rd, 32'h77777777);
`endif

    // Reset while a read response is pending.
    rready = 1'b0;
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    check_eq("pre_rst_rvalid", 32'(rvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("rst_drops_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_drops_arready", 32'(arready), 32'd0);
    check_eq("rst_rdata_zero", rdata, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    rready = 1'b1;
    repeat (3) tick();
    check_eq("no_resp_after_rst", 32'(rvalid), 32'd0);
    do_read(32'h10, rd, rsp);
    check_eq("mem_kept_over_rst", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
